// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the RV32I multi-cycle controller: state and
//   instruction-class encodings, major opcode constants, immediate-extender
//   op codes and ALU op codes.
//   Optional feature macro: CTRL_SHAMT_EN (consumed by multicycle_ctrl).
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CLS_R     = 2'd0,
        CLS_IALU  = 2'd1,
        CLS_LOAD  = 2'd2,
        CLS_STORE = 2'd3
    } class_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    localparam logic [2:0] EXT_CTRL_NONE        = 3'b000;
    localparam logic [2:0] EXT_CTRL_STYPE       = 3'b001;
    localparam logic [2:0] EXT_CTRL_ITYPE       = 3'b010;
    localparam logic [2:0] EXT_CTRL_ITYPE_SHAMT = 3'b100;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // States in which the controller owns an outstanding memory request.
    function automatic logic waits_on_mem(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_mem_wait_timer
//   Memory wait timer: counts cycles a request has waited for mem_ready.
//   Ports:
//     clk        in   clock, rising edge
//     rstn       in   asynchronous active-low reset
//     clr_i      in   clear counter to zero (wins over en_i)
//     en_i       in   count one waited cycle
//     expired_o  out  counter has reached MEM_TIMEOUT
// ---------------------------------------------------------------------------
module multicycle_ctrl_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control FSM for an RV32I datapath. Sequences
//   fetch/decode/execute/memory/writeback, drives the immediate-extender op,
//   ALU selects and write enables, owns the memory handshake, and traps on
//   illegal opcodes or memory timeout.
//
//   Optional feature macro: CTRL_SHAMT_EN
//     defined   : OP-IMM shifts (slli/srli/srai) are legal, ext_op = 100
//     undefined : OP-IMM funct3 001/101 trap
//
//   Ports:
//     clk        in   clock, rising edge
//     rstn       in   asynchronous active-low reset
//     instr      in   IR contents (valid from DECODE onward)
//     mem_ready  in   memory completes request this cycle
//     mem_req    out  memory request active
//     mem_we     out  request is a store
//     pc_write   out  PC <= PC+4
//     ir_write   out  IR <= fetched word
//     ext_op     out  immediate-extender op
//     alu_src_b  out  1 = immediate, 0 = rs2
//     alu_op     out  00 add, 10 decode funct3/funct7
//     reg_write  out  register file write enable
//     wd_sel     out  0 = ALU result, 1 = load data
//     trap       out  sticky fault indicator
//     state      out  current state (debug)
//
//   state  | meaning
//   IDLE   | post-reset, one cycle
//   FETCH  | instruction read; IR/PC written on mem_ready
//   DECODE | classify opcode, latch class and extender op
//   EXEC   | ALU operation / address generation
//   MEM    | data load or store
//   WB     | register file write
//   TRAP   | illegal opcode or memory timeout; left only by reset
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_write,
    output logic        ir_write,
    output logic [2:0]  ext_op,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        wd_sel,
    output logic        trap,
    output logic [2:0]  state
);

    state_e     state_q, state_d;
    class_e     cls_q, cls_d;
    logic [2:0] ext_q, ext_d;

    logic       timer_clr;
    logic       timer_en;
    logic       timer_expired;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       dec_legal;
    class_e     dec_cls;
    logic [2:0] dec_ext;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

`ifdef CTRL_SHAMT_EN
    assign unused_instr = ^{instr[24:15], instr[11:7]};
`else
    assign unused_instr = ^{funct7, instr[24:15], instr[11:7]};
`endif

    // Opcode classification; illegal encodings leave the extender idle.
    always_comb begin
        dec_legal = 1'b0;
        dec_cls   = CLS_R;
        dec_ext   = EXT_CTRL_NONE;
        case (opcode)
            OPC_OP: begin
                dec_legal = 1'b1;
                dec_cls   = CLS_R;
            end
            OPC_OP_IMM: begin
                dec_cls = CLS_IALU;
                if ((funct3 == F3_SLL) || (funct3 == F3_SRL)) begin
`ifdef CTRL_SHAMT_EN
                    dec_ext   = EXT_CTRL_ITYPE_SHAMT;
                    dec_legal = (funct7 == F7_ZERO) ||
                                ((funct3 == F3_SRL) && (funct7 == F7_SRA));
`else
                    dec_legal = 1'b0;
`endif
                end else begin
                    dec_ext   = EXT_CTRL_ITYPE;
                    dec_legal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_legal = 1'b1;
                dec_cls   = CLS_LOAD;
                dec_ext   = EXT_CTRL_ITYPE;
            end
            OPC_STORE: begin
                dec_legal = 1'b1;
                dec_cls   = CLS_STORE;
                dec_ext   = EXT_CTRL_STYPE;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        if (!dec_legal) begin
            dec_ext = EXT_CTRL_NONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_R;
            ext_q   <= EXT_CTRL_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            ext_q   <= ext_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        ext_d     = ext_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        ext_op    = EXT_CTRL_NONE;
        alu_src_b = 1'b0;
        alu_op    = ALU_OP_ADD;
        reg_write = 1'b0;
        wd_sel    = 1'b0;
        trap      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                // Extender is registered, so its op must be presented while
                // decoding for the immediate to be ready in EXEC.
                ext_op  = dec_ext;
                cls_d   = dec_cls;
                ext_d   = dec_ext;
                state_d = dec_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                ext_op    = ext_q;
                alu_src_b = (cls_q != CLS_R);
                alu_op    = ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) ?
                            ALU_OP_ADD : ALU_OP_FUNCT;
                state_d   = ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) ?
                            ST_MEM : ST_WB;
            end
            ST_MEM: begin
                ext_op  = ext_q;
                mem_req = 1'b1;
                mem_we  = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                ext_op    = ext_q;
                reg_write = 1'b1;
                wd_sel    = (cls_q == CLS_LOAD);
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // Any state change clears the timer, which covers every entry to FETCH
    // or MEM (including MEM -> FETCH after a store).
    assign timer_clr = (state_d != state_q);
    assign timer_en  = waits_on_mem(state_q) && !mem_ready;

    multicycle_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    assign state = state_q;

endmodule
